// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer, flag and overflow-statistics controller for the async FIFO.
// The read pointer is synchronized in as Gray; full and level may lag reads but never understate occupancy.
module fifo_wr_ctrl #(
  parameter int PTR_WIDTH     = 8,
  parameter int DEPTH         = 256,
  parameter int AF_THRESH     = 240,
  parameter int SYNC_STAGES   = 2,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     w_clk,
  input  logic                     wrst_n,
  input  logic                     w_en,
  input  logic [PTR_WIDTH:0]       g_rptr,
  input  logic                     err_clr,
  output logic [PTR_WIDTH:0]       b_wptr,
  output logic [PTR_WIDTH:0]       g_wptr,
  output logic                     full,
  output logic                     almost_full,
  output logic [PTR_WIDTH:0]       wr_level,
  output logic                     wr_ack,
  output logic                     overflow_sticky,
  output logic [ERR_CNT_WIDTH-1:0] overflow_cnt
);

  localparam int PW     = PTR_WIDTH + 1;
  localparam int AF_LIM = (AF_THRESH > DEPTH) ? DEPTH : AF_THRESH;
  localparam logic [PW-1:0]            AF_VAL  = PW'(AF_LIM);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0]            r_b_wptr;
  logic [PW-1:0]            r_g_wptr;
  logic                     r_full;
  logic                     r_almost_full;
  logic [PW-1:0]            r_wr_level;
  logic                     r_wr_ack;
  logic                     r_ovf_sticky;
  logic [ERR_CNT_WIDTH-1:0] r_ovf_cnt;
  logic [PW-1:0]            r_rq [SYNC_STAGES];

  logic                     w_push;
  logic                     w_ovf;
  logic [PW-1:0]            w_b_wnext;
  logic [PW-1:0]            w_g_wnext;
  logic [PW-1:0]            w_rq_s;
  logic [PW-1:0]            w_rbin;
  logic [PW-1:0]            w_level;
  logic [PW-1:0]            w_full_cmp;

  assign w_push     = w_en & ~r_full;
  assign w_ovf      = w_en & r_full;
  assign w_b_wnext  = r_b_wptr + {{(PW-1){1'b0}}, w_push};
  assign w_g_wnext  = w_b_wnext ^ (w_b_wnext >> 1);
  assign w_rq_s     = r_rq[SYNC_STAGES-1];
  assign w_rbin     = gray2bin(w_rq_s);
  assign w_level    = w_b_wnext - w_rbin;
  // Full when the next write pointer is exactly one lap ahead of the synchronized read pointer.
  assign w_full_cmp = {~w_rq_s[PW-1:PW-2], w_rq_s[PW-3:0]};

  // Read-pointer synchronizer: plain flop chain, no logic on g_rptr before the last stage.
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_rq[i] <= {PW{1'b0}};
      end
    end else begin
      r_rq[0] <= g_rptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_rq[i] <= r_rq[i-1];
      end
    end
  end

  // Write pointers, flags, level and acknowledge.
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_b_wptr      <= {PW{1'b0}};
      r_g_wptr      <= {PW{1'b0}};
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_wr_level    <= {PW{1'b0}};
      r_wr_ack      <= 1'b0;
    end else begin
      r_b_wptr      <= w_b_wnext;
      r_g_wptr      <= w_g_wnext;
      r_full        <= (w_g_wnext == w_full_cmp);
      r_almost_full <= (w_level >= AF_VAL);
      r_wr_level    <= w_level;
      r_wr_ack      <= w_push;
    end
  end

  // Overflow statistics; a clear wins over a same-cycle rejected write.
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_cnt    <= {ERR_CNT_WIDTH{1'b0}};
    end else if (err_clr) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_cnt    <= {ERR_CNT_WIDTH{1'b0}};
    end else if (w_ovf) begin
      r_ovf_sticky <= 1'b1;
      if (r_ovf_cnt != CNT_MAX) begin
        r_ovf_cnt <= r_ovf_cnt + CNT_ONE;
      end
    end
  end

  assign b_wptr          = r_b_wptr;
  assign g_wptr          = r_g_wptr;
  assign full            = r_full;
  assign almost_full     = r_almost_full;
  assign wr_level        = r_wr_level;
  assign wr_ack          = r_wr_ack;
  assign overflow_sticky = r_ovf_sticky;
  assign overflow_cnt    = r_ovf_cnt;

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
- Write-domain pointer and flag controller for the async FIFO. Sits directly upstream of fifo_mem.
- Generates the binary write pointer b_wptr that addresses fifo_mem, and the Gray write pointer g_wptr exported to the read domain.
- Synchronizes the read-domain Gray pointer into w_clk and derives full, almost_full, fill level and overflow statistics.
- Read-side counterpart is a separate block.

Parameters:
- PTR_WIDTH, 8, address bits; pointers are PTR_WIDTH+1 bits wide.
- DEPTH, 256, FIFO entries; must equal 2**PTR_WIDTH.
- AF_THRESH, 240, level at or above which almost_full asserts; legal range 1..DEPTH.
- SYNC_STAGES, 2, flop stages in the g_rptr synchronizer; minimum 2.
- ERR_CNT_WIDTH, 16, width of the overflow counter.

Ports:
- w_clk  input  1  write clock; the only clock of this block.
- wrst_n  input  1  asynchronous, active-low reset.
- w_en  input  1  write request from producer.
- g_rptr  input  PTR_WIDTH+1  Gray read pointer, launched from r_clk domain.
- err_clr  input  1  synchronous clear of overflow_cnt and overflow_sticky.
- b_wptr  output  PTR_WIDTH+1  binary write pointer to fifo_mem.
- g_wptr  output  PTR_WIDTH+1  Gray write pointer to read domain; registered.
- full  output  1  FIFO full; registered.
- almost_full  output  1  level >= AF_THRESH; registered.
- wr_level  output  PTR_WIDTH+1  write-side fill level, 0..DEPTH.
- wr_ack  output  1  one-cycle pulse: write accepted on previous edge.
- overflow_sticky  output  1  set on any write attempted while full.
- overflow_cnt  output  ERR_CNT_WIDTH  saturating count of rejected writes.

Behaviour:
- Reset (wrst_n=0, async assert, released on w_clk): all outputs and synchronizer flops go to 0, so full=0 and wr_level=0.
- push = w_en & ~full.
- b_wnext = b_wptr + push, mod 2**(PTR_WIDTH+1); wrap from all-ones to 0 is natural.
- g_wnext = b_wnext ^ (b_wnext >> 1).
- b_wptr and g_wptr both register on every w_clk edge. g_wptr must come straight from a flop, with no combinational path to the output.
- Synchronizer: rq[0] <= g_rptr, then rq[i] <= rq[i-1]. rq_s = rq[SYNC_STAGES-1]. No other logic touches g_rptr before rq_s.
- Full, registered: full <= (g_wnext == {~rq_s[MSB:MSB-1], rq_s[MSB-2:0]}). Full asserts on the same edge that accepts the DEPTH-th outstanding write.
- Read-pointer conversion: rbin = gray-to-binary of rq_s, as an XOR prefix from the MSB.
- Fill level, registered: wr_level <= b_wnext - rbin, modulo PTR_WIDTH+1 bits; the result is exact 0..DEPTH.
- almost_full <= ((b_wnext - rbin) >= AF_THRESH).
- Pessimism: wr_level and full may overstate occupancy by up to SYNC_STAGES+1 r_clk/w_clk crossings. They never understate it.
- wr_ack <= push.
- Overflow: when w_en & full, overflow_sticky <= 1 and overflow_cnt increments, saturating at all-ones. b_wptr is unchanged.
- err_clr has priority over a same-cycle overflow: counter to 0, sticky to 0.
- Read advance visibility: a change on g_rptr reaches rq_s after SYNC_STAGES edges. full, wr_level and almost_full update on the following edge.
- Simultaneous push and read advance: each is handled independently. With SYNC_STAGES=2, the level reflects the push one edge after it and the read 3 edges after it.
- Reset mid-operation: immediate return to reset values. The read side must be reset concurrently; behaviour is undefined otherwise.

Test Plan:
- Reset: assert wrst_n=0 mid-burst with b_wptr=0x05A -> all outputs 0 without waiting for a clock edge. After release, the first push gives b_wptr=0x001, g_wptr=0x001.
- Fill: g_rptr=0 held, 256 consecutive w_en cycles -> full=1 on the edge of the 256th push, wr_level=256, b_wptr=0x100, g_wptr=0x180. almost_full rises on the 240th push.
- Overflow: while full, 3 cycles of w_en -> b_wptr stays 0x100, wr_ack=0, overflow_cnt=3, overflow_sticky=1. Then err_clr=1 together with another w_en -> count 0, sticky 0.
- Drain visibility: from full, step g_rptr Gray 0x000->0x001 -> full stays 1 for 2 edges, then clears on the 3rd edge with wr_level=255.
- Wrap: preload by running rptr/wptr to 0x1FE with level 0, then 4 pushes -> b_wptr sequence 0x1FF, 0x000, 0x001, 0x002. Gray values 0x100, 0x000 at the wrap. wr_level=4, no false full.
- Saturation: force 2**ERR_CNT_WIDTH+5 rejected writes (ERR_CNT_WIDTH=4 override) -> overflow_cnt holds 0xF.
